// File: rtl/led_frame_pkg.sv
// Shared register map, CTRL bit positions and AXI response codes
// for the LED frame sender control block.
package led_frame_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_FRAME  = 2'd1,
        REG_COLOR  = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_FRAME  = 4'h4;
    localparam logic [3:0] OFF_COLOR  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ENABLE = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/led_frame_axil_regs.sv
// AXI4-Lite register block driving the LED frame sender:
// CTRL/FRAME/COLOR registers plus a read-only STATUS word.
module led_frame_axil_regs
    import led_frame_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            ctrl_enable,
    output logic                            start_pulse,
    output logic [31:0]                     frame_word,
    output logic [31:0]                     color_word,
    input  logic                            busy,
    input  logic                            frame_done
);

    logic [31:0] ctrl_q;
    logic [31:0] frame_q;
    logic [31:0] color_q;
    logic [15:0] frame_cnt;
    logic [31:0] rd_mux;
    logic        wr_en;
    logic        rd_en;
    reg_sel_e    wr_sel;
    reg_sel_e    rd_sel;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_sel = reg_sel_e'(S_AXI_AWADDR[3:2]);
    assign rd_sel = reg_sel_e'(S_AXI_ARADDR[3:2]);
    assign wr_en  = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en  = S_AXI_ARREADY && S_AXI_ARVALID;

    assign S_AXI_BRESP = RESP_OKAY;
    assign S_AXI_RRESP = RESP_OKAY;
    assign ctrl_enable = ctrl_q[CTRL_ENABLE];
    assign frame_word  = frame_q;
    assign color_word  = color_q;

    always_comb begin
        rd_mux = '0;
        unique case (rd_sel)
            REG_CTRL:   rd_mux = ctrl_q;
            REG_FRAME:  rd_mux = frame_q;
            REG_COLOR:  rd_mux = color_q;
            REG_STATUS: rd_mux = {frame_cnt, 15'd0, busy};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            start_pulse   <= 1'b0;
            ctrl_q        <= '0;
            frame_q       <= '0;
            color_q       <= '0;
            frame_cnt     <= '0;
        end else begin
            // Ready pulses for one cycle only once both channels present
            S_AXI_AWREADY <= !S_AXI_AWREADY && S_AXI_AWVALID
                             && S_AXI_WVALID && !S_AXI_BVALID;
            S_AXI_WREADY  <= !S_AXI_AWREADY && S_AXI_AWVALID
                             && S_AXI_WVALID && !S_AXI_BVALID;
            start_pulse   <= 1'b0;

            if (wr_en) begin
                S_AXI_BVALID <= 1'b1;
                unique case (wr_sel)
                    REG_CTRL: begin
                        ctrl_q <= apply_strb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB)
                                  & ~32'h1;
                        start_pulse <= S_AXI_WSTRB[0]
                                       && S_AXI_WDATA[CTRL_START];
                    end
                    REG_FRAME: frame_q <= apply_strb(frame_q, S_AXI_WDATA,
                                                     S_AXI_WSTRB);
                    REG_COLOR: color_q <= apply_strb(color_q, S_AXI_WDATA,
                                                     S_AXI_WSTRB);
                    default: ;
                endcase
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID
                             && !S_AXI_RVALID;
            if (rd_en) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end

            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_led_frame_axil_regs.sv
// Directed self-checking bench for led_frame_axil_regs.
// Expected values are hand-computed from the register map.
module tb_led_frame_axil_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        ctrl_enable;
    logic        start_pulse;
    logic [31:0] frame_word;
    logic [31:0] color_word;
    logic        busy = 1'b0;
    logic        frame_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    led_frame_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_enable(ctrl_enable), .start_pulse(start_pulse),
        .frame_word(frame_word), .color_word(color_word),
        .busy(busy), .frame_done(frame_done)
    );

    always @(negedge clk) if (start_pulse) start_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        bit ok;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        check("wr_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bvalid) begin ok = 1; break; end
            @(negedge clk);
        end
        check("wr_bvalid", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        bit ok;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        check("rd_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        ok = 0;
        d = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1; d = rdata; break; end
        end
        check("rd_rvalid", 32'(ok), 32'd1);
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rd2;
        int hi;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {awready, wready, arready, bvalid, rvalid,
                            start_pulse}, 32'd0);
        check("rst_frame", frame_word, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // basic write/readback
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        axi_read(4'h0, rd); check("rb_ctrl", rd, 32'h0);
        axi_read(4'h4, rd); check("rb_frame", rd, 32'h2);
        axi_read(4'h8, rd); check("rb_color", rd, 32'h3);
        axi_read(4'hC, rd); check("rb_status", rd, 32'h0);
        check("start_once", start_cnt, 32'd1);
        check("out_color", color_word, 32'h3);

        // enable bit, scratch bits, START not retained
        axi_write(4'h0, 32'hA5A5_0003, 4'hF);
        check("enable", ctrl_enable, 32'd1);
        check("start_twice", start_cnt, 32'd2);
        axi_read(4'h0, rd); check("ctrl_scratch", rd, 32'hA5A5_0002);

        // start needs WSTRB[0]
        axi_write(4'h0, 32'h0000_0001, 4'hE);
        check("start_strb", start_cnt, 32'd2);

        // byte strobes, addr[1:0] ignored
        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'h7, 32'h1122_3344, 4'b0101);
        axi_read(4'h5, rd); check("strb", rd, 32'hFF22_FF44);
        check("out_frame", frame_word, 32'hFF22_FF44);

        // AW before W, BREADY held low
        awaddr = 4'h8; wdata = 32'hCAFE_0001; wstrb = 4'hF;
        awvalid = 1'b1; bready = 1'b0;
        hi = 0;
        repeat (3) begin
            @(negedge clk);
            if (awready || wready) hi++;
        end
        check("aw_only_ready", hi, 32'd0);
        @(posedge clk); #1 wvalid = 1'b1;
        @(negedge clk);
        check("both_ready", {awready, wready}, 32'd0);
        @(negedge clk);
        check("both_ready2", {awready, wready, bvalid}, 32'b110);
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (bvalid) hi++;
        end
        check("bvalid_hold", hi, 32'd5);
        check("bresp", bresp, 32'd0);
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check("bvalid_clr", bvalid, 32'd0);

        // same-cycle read and write to COLOR: read sees old value
        fork
            axi_write(4'h8, 32'hDEAD_BEEF, 4'hF);
            axi_read(4'h8, rd);
        join
        check("rw_same", rd, 32'hCAFE_0001);
        axi_read(4'h8, rd2); check("rw_after", rd2, 32'hDEAD_BEEF);

        // frame counter wrap
        busy = 1'b1;
        @(posedge clk); #1 frame_done = 1'b1;
        repeat (65537) @(posedge clk);
        #1 frame_done = 1'b0;
        axi_read(4'hC, rd); check("status_wrap", rd, 32'h0001_0001);
        check("rresp", rresp, 32'd0);
        busy = 1'b0;

        // reset during pending read
        araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rvalid) begin hi = 1; break; end
        end
        arvalid = 1'b0;
        check("rvalid_pend", hi, 32'd1);
        #1 rst = 1'b1;
        #1 check("rst_rvalid", {rvalid, ctrl_enable}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        axi_read(4'h0, rd); check("post_ctrl", rd, 32'h0);
        axi_read(4'h4, rd); check("post_frame", rd, 32'h0);
        axi_read(4'h8, rd); check("post_color", rd, 32'h0);
        axi_read(4'hC, rd); check("post_status", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
